// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int BYTE_W    = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    WAIT_DROP = 2'd2
  } rx_state_e;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bundles the receiver handshake (req/data/ack) and the consumer valid/ready stream.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer; rcv_ack paces the receiver.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic  rcv_req;
  byte_t rcv_data;
  logic  rcv_ack;
  logic  out_valid;
  byte_t out_data;
  logic  out_ready;

  // Controller side: answers the receiver and sources the byte stream.
  modport master (
    input  rcv_req,
    input  rcv_data,
    output rcv_ack,
    output out_valid,
    output out_data,
    input  out_ready
  );

  // Environment side: receiver plus byte consumer.
  modport slave (
    output rcv_req,
    output rcv_data,
    input  rcv_ack,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/rx_byte_fifo.sv
// DEPTH x 8 synchronous FIFO with separate occupancy counter.
// Latency: a push is visible at the head one cycle later (no bypass).
// Backpressure: push accepted when not full or when a pop happens the same cycle.
module rx_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  byte_t         push_dat,
  input  logic          pop,
  output byte_t         pop_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Pop on empty is ignored; full still accepts a push when the head leaves this cycle.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // Pointer and occupancy next-state; pointers wrap naturally at power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Gates the UART receiver, acks each byte once, buffers bytes and flags overruns.
// Latency: captured byte appears on out_valid/out_data the cycle after capture.
// Backpressure: out_ready pops the FIFO; a capture into a full FIFO without a pop is dropped.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            en,
  output logic            rx_clr,
  uart_rx_ctrl_if.master  bus,
  output logic [CW-1:0]   fifo_count,
  output logic            overrun,
  input  logic            ovr_clr
);

  rx_state_e state_q, state_d;
  logic      rcv_ack_q, rcv_ack_d;
  logic      rx_clr_q, rx_clr_d;
  logic      overrun_q, overrun_d;
  logic      capture, pop, drop;
  logic      fifo_full, fifo_empty;

  // FSM state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: one capture per req pulse, ack must be seen low before the next req.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (bus.rcv_req)  state_d = ACK;
        ACK:       if (!bus.rcv_req) state_d = WAIT_DROP;
        WAIT_DROP: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: capture strobe and registered ack derived from the next state.
  always_comb begin
    capture   = (state_q == IDLE) & en & bus.rcv_req;
    rcv_ack_d = (state_d == ACK);
  end

  assign pop  = ~fifo_empty & bus.out_ready;
  assign drop = capture & fifo_full & ~pop;

  // Receiver clear follows enable; overrun is sticky with set taking priority over clear.
  always_comb begin
    rx_clr_d  = ~en;
    overrun_d = overrun_q;
    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rcv_ack_q <= 1'b0;
      rx_clr_q  <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      rcv_ack_q <= rcv_ack_d;
      rx_clr_q  <= rx_clr_d;
      overrun_q <= overrun_d;
    end
  end

  rx_byte_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (clr_n),
    .push     (capture),
    .push_dat (bus.rcv_data),
    .pop      (pop),
    .pop_dat  (bus.out_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.rcv_ack   = rcv_ack_q;
  assign bus.out_valid = ~fifo_empty;
  assign rx_clr        = rx_clr_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with hand-computed expectations.
// Latency: n/a.
// Backpressure: consumer ready driven explicitly per scenario.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          en;
  logic          rx_clr;
  logic [CW-1:0] fifo_count;
  logic          overrun;
  logic          ovr_clr;
  int            checks = 0;
  int            failures = 0;
  int            handshakes = 0;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .en         (en),
    .rx_clr     (rx_clr),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // Step one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full receiver handshake with bounded waits on ack.
  task automatic send(input logic [7:0] d);
    int n;
    bus.rcv_data = d;
    bus.rcv_req  = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.rcv_ack && n < 10);
    chk("hs_ack_rise", bus.rcv_ack, 1);
    repeat (2) tick();
    bus.rcv_req = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.rcv_ack && n < 10);
    chk("hs_ack_fall", bus.rcv_ack, 0);
    tick();
    handshakes++;
  endtask

  task automatic drain_one(input logic [7:0] e);
    chk("drain_vld", bus.out_valid, 1);
    chk("drain_dat", bus.out_data, e);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n         = 1'b0;
    en            = 1'b0;
    ovr_clr       = 1'b0;
    bus.rcv_req   = 1'b0;
    bus.rcv_data  = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_ack", bus.rcv_ack, 0);
    chk("rst_rx_clr", rx_clr, 1);
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovr", overrun, 0);

    // Release with enable: rx_clr drops one cycle later
    clr_n = 1'b1;
    en    = 1'b1;
    chk("en_rx_clr_before", rx_clr, 1);
    tick();
    chk("en_rx_clr_after", rx_clr, 0);

    // Single byte, req held 8 cycles
    bus.rcv_data = 8'hA5;
    bus.rcv_req  = 1'b1;
    chk("sb_ack_pre", bus.rcv_ack, 0);
    tick();
    chk("sb_ack_rise", bus.rcv_ack, 1);
    chk("sb_count", fifo_count, 1);
    chk("sb_vld", bus.out_valid, 1);
    chk("sb_dat", bus.out_data, 8'hA5);
    repeat (7) tick();
    chk("sb_count_hold", fifo_count, 1);
    chk("sb_ack_hold", bus.rcv_ack, 1);
    bus.rcv_req = 1'b0;
    tick();
    chk("sb_ack_fall", bus.rcv_ack, 0);
    tick();
    drain_one(8'hA5);
    chk("sb_empty", bus.out_valid, 0);

    // Fill past depth with consumer stalled
    handshakes = 0;
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("fill_count4", fifo_count, 4);
    chk("fill_ovr0", overrun, 0);
    send(8'h05);
    chk("fill_count_full", fifo_count, 4);
    chk("fill_ovr1", overrun, 1);
    chk("fill_hs", handshakes, 5);
    for (int i = 1; i <= 4; i++) drain_one(8'(i));
    chk("fill_empty", bus.out_valid, 0);
    chk("fill_ovr_sticky", overrun, 1);

    // ovr_clr with no drop
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("oc_cleared", overrun, 0);

    // Full plus simultaneous pop on the capture cycle
    for (int i = 1; i <= 4; i++) send(8'h10 + 8'(i));
    chk("sp_full", fifo_count, 4);
    bus.rcv_data  = 8'h10;
    bus.rcv_req   = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("sp_count", fifo_count, 4);
    chk("sp_ovr", overrun, 0);
    chk("sp_head", bus.out_data, 8'h12);
    repeat (2) tick();
    bus.rcv_req = 1'b0;
    tick();
    chk("sp_ack_fall", bus.rcv_ack, 0);
    tick();
    drain_one(8'h12);
    drain_one(8'h13);
    drain_one(8'h14);
    drain_one(8'h10);
    chk("sp_empty", bus.out_valid, 0);

    // ovr_clr coincident with a drop: set wins
    for (int i = 1; i <= 4; i++) send(8'h20 + 8'(i));
    bus.rcv_data = 8'h25;
    bus.rcv_req  = 1'b1;
    ovr_clr      = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("oc_set_wins", overrun, 1);
    chk("oc_count", fifo_count, 4);
    repeat (2) tick();
    bus.rcv_req = 1'b0;
    repeat (2) tick();
    for (int i = 1; i <= 4; i++) drain_one(8'h20 + 8'(i));

    // Disable while in ACK
    bus.rcv_data = 8'h33;
    bus.rcv_req  = 1'b1;
    tick();
    chk("dis_ack1", bus.rcv_ack, 1);
    en = 1'b0;
    tick();
    chk("dis_ack0", bus.rcv_ack, 0);
    chk("dis_rx_clr", rx_clr, 1);
    chk("dis_count", fifo_count, 1);
    chk("dis_dat", bus.out_data, 8'h33);
    tick();
    chk("dis_no_capture", fifo_count, 1);
    bus.rcv_req = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk("reen_rx_clr", rx_clr, 0);
    send(8'h44);
    chk("reen_count", fifo_count, 2);
    drain_one(8'h33);
    drain_one(8'h44);

    // Asynchronous reset in the middle of ACK
    bus.rcv_data = 8'h55;
    bus.rcv_req  = 1'b1;
    tick();
    chk("mr_ack1", bus.rcv_ack, 1);
    chk("mr_vld1", bus.out_valid, 1);
    #1 clr_n = 1'b0;
    #1;
    chk("mr_ack0", bus.rcv_ack, 0);
    chk("mr_rx_clr", rx_clr, 1);
    chk("mr_vld0", bus.out_valid, 0);
    chk("mr_count", fifo_count, 0);
    bus.rcv_req = 1'b0;
    tick();
    clr_n = 1'b1;
    tick();
    chk("mr_rx_clr_rel", rx_clr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
